dest_ip_filter_reg_ctrl: RTL and testbench
==========================================

Name: dest_ip_filter_reg_ctrl

Overview:
Register-side initiator for the destination-IP filter CAM table. Converts single-cycle host register accesses into the table's read/write request/acknowledge handshake. Drives rd_req/wr_req plus address/IP toward the CAM LUT state machine and captures read-back data. Reports busy, error and timeout status. Sits between the pcore register decoder and the dest IP filter's table read/write ports.

Parameters:
LUT_DEPTH, 32, number of table entries
LUT_DEPTH_BITS, log2(LUT_DEPTH), table address width
TIMEOUT_BITS, 10, width of ack-wait counter; timeout fires at count 2**TIMEOUT_BITS-1

Ports:
clk  in  1  single clock for the whole block
resetn  in  1  asynchronous, active-low reset
reg_req  in  1  host access strobe, one cycle per access
reg_rnw  in  1  1=read, 0=write, valid with reg_req
reg_addr  in  2  0=IP, 1=ENTRY, 2=CMD, 3=STATUS
reg_wdata  in  32  host write data
reg_ack  out  1  pulses one cycle after each reg_req
reg_rdata  out  32  read data, valid with reg_ack
tbl_rd_addr  out  LUT_DEPTH_BITS  table read address
tbl_rd_req  out  1  read request, level, held until ack
tbl_rd_ip  in  32  read-back IP, valid with tbl_rd_ack
tbl_rd_ack  in  1  read acknowledge pulse
tbl_wr_addr  out  LUT_DEPTH_BITS  table write address
tbl_wr_req  out  1  write request, level, held until ack
tbl_wr_ip  out  32  IP to write
tbl_wr_ack  in  1  write acknowledge pulse

Behaviour:
- Reset (resetn=0, async): all outputs 0; IP, ENTRY, STATUS regs 0; FSM=IDLE; timeout counter 0.
- Registers:
  - IP (RW, 32b).
  - ENTRY (RW, low LUT_DEPTH_BITS bits; upper bits read 0).
  - CMD (W; bit0=WRITE_ENTRY, bit1=READ_ENTRY; reads 0).
  - STATUS (R): bit0 busy, bit1 done (sticky), bit2 timeout (sticky), bit3 cmd_err (sticky). Reading STATUS returns the current value, then clears bits 1-3 on the same clock edge as reg_ack. A set event coincident with the clear wins.
- reg_ack asserts exactly 1 cycle after reg_req regardless of FSM state. reg_rdata = 0 on writes and when not acking.
- tbl_wr_addr = tbl_rd_addr = ENTRY; tbl_wr_ip = IP. Writes to IP/ENTRY while busy are ignored and set cmd_err.
- FSM states:
  - IDLE: CMD write with 2'b01 -> WR_WAIT, with 2'b10 -> RD_WAIT, next cycle (req asserted the cycle after reg_req). CMD=2'b00: no-op. CMD=2'b11: no op, set cmd_err.
  - WR_WAIT: tbl_wr_req=1. On tbl_wr_ack -> IDLE, req low next cycle, set done.
  - RD_WAIT: tbl_rd_req=1. On tbl_rd_ack, latch tbl_rd_ip into IP -> IDLE, set done.
  - busy = (state != IDLE).
- Any CMD write while busy is ignored and sets cmd_err.
- Timeout counter clears on entry to a WAIT state and increments each cycle in that state. When it reaches all-ones without an ack: drop req, set timeout, go to IDLE; IP unchanged on read timeout.
- Ack arriving in the same cycle the counter hits all-ones: ack wins, no timeout.
- Acks in IDLE, or of the wrong type (rd_ack in WR_WAIT), are ignored.
- Ack may arrive the first cycle req is high; minimum op = 2 cycles of req-to-IDLE.
- resetn asserted mid-operation: req drops immediately (async); the op is lost.

Test Plan:
1. Table write: write IP=0xC0A80001, ENTRY=5, CMD=1. Required: tbl_wr_req rises 1 cycle after CMD, wr_addr=5, wr_ip=0xC0A80001. Ack after 3 cycles -> req falls next cycle. STATUS read=0x2, second read=0x0.
2. Table read: ENTRY=7, CMD=2, tbl_rd_ack with tbl_rd_ip=0x0A000001. Required: IP reads 0x0A000001, STATUS=0x2.
3. Timeout (TIMEOUT_BITS=4): CMD=1, never ack. Required: req drops after 15 cycles; STATUS=0x4; a later wr_ack is ignored with no status change.
4. Busy collision: CMD=1, then write IP=0xFFFFFFFF and CMD=2 before ack. Required: IP unchanged, no rd_req; STATUS after ack=0xA.
5. CMD=3 in IDLE. Required: no req; STATUS=0x8. CMD=0: nothing changes.
6. Async reset: assert resetn=0 mid RD_WAIT, between clock edges. Required: tbl_rd_req low immediately; all regs 0 after release.

Source files
------------

// File: rtl/dest_ip_filter_reg_ctrl_if.sv
// Register bus plus CAM table read/write handshake bundle for the dest-IP filter
// register controller. slave = controller side, master = host/table side.
interface dest_ip_filter_reg_ctrl_if #(
  parameter int unsigned ADDR_BITS = 5
);
  logic                 reg_req;
  logic                 reg_rnw;
  logic [1:0]           reg_addr;
  logic [31:0]          reg_wdata;
  logic                 reg_ack;
  logic [31:0]          reg_rdata;
  logic [ADDR_BITS-1:0] tbl_rd_addr;
  logic                 tbl_rd_req;
  logic [31:0]          tbl_rd_ip;
  logic                 tbl_rd_ack;
  logic [ADDR_BITS-1:0] tbl_wr_addr;
  logic                 tbl_wr_req;
  logic [31:0]          tbl_wr_ip;
  logic                 tbl_wr_ack;

  modport master (
    output reg_req, reg_rnw, reg_addr, reg_wdata, tbl_rd_ip, tbl_rd_ack, tbl_wr_ack,
    input  reg_ack, reg_rdata, tbl_rd_addr, tbl_rd_req, tbl_wr_addr, tbl_wr_req, tbl_wr_ip
  );

  modport slave (
    input  reg_req, reg_rnw, reg_addr, reg_wdata, tbl_rd_ip, tbl_rd_ack, tbl_wr_ack,
    output reg_ack, reg_rdata, tbl_rd_addr, tbl_rd_req, tbl_wr_addr, tbl_wr_req, tbl_wr_ip
  );
endinterface

// File: rtl/dest_ip_filter_reg_ctrl.sv
// Host-register front end for the destination-IP filter CAM table: turns
// single-cycle register accesses into table read/write request/ack handshakes.
module dest_ip_filter_reg_ctrl #(
  parameter int unsigned LUT_DEPTH      = 32,
  parameter int unsigned LUT_DEPTH_BITS = $clog2(LUT_DEPTH),
  parameter int unsigned TIMEOUT_BITS   = 10
) (
  input logic                      clk,
  input logic                      resetn,
  dest_ip_filter_reg_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;
  typedef enum logic [1:0] {A_IP = 2'd0, A_ENTRY = 2'd1, A_CMD = 2'd2, A_STATUS = 2'd3} addr_t;

  // Counter lands on all-ones on the same edge that abandons the wait.
  localparam logic [TIMEOUT_BITS-1:0] CNT_LAST = ~TIMEOUT_BITS'(1);

  state_t                    state, state_nxt;
  addr_t                     addr;
  logic [31:0]               ip;
  logic [LUT_DEPTH_BITS-1:0] entry;
  logic [TIMEOUT_BITS-1:0]   cnt;
  logic                      done, timeout, cmd_err, busy;
  logic                      wr_acc, rd_acc, cmd_wr, finish, expire, err_set, sts_clr;

  assign addr    = addr_t'(bus.reg_addr);
  assign wr_acc  = bus.reg_req & ~bus.reg_rnw;
  assign rd_acc  = bus.reg_req & bus.reg_rnw;
  assign cmd_wr  = wr_acc && (addr == A_CMD);
  assign finish  = (state == WR_WAIT && bus.tbl_wr_ack) || (state == RD_WAIT && bus.tbl_rd_ack);
  assign expire  = (state != IDLE) && !finish && (cnt == CNT_LAST);
  assign err_set = wr_acc && ((busy && addr != A_STATUS) ||
                              (!busy && addr == A_CMD && bus.reg_wdata[1:0] == 2'b11));
  assign sts_clr = rd_acc && (addr == A_STATUS);

  assign bus.tbl_rd_addr = entry;
  assign bus.tbl_wr_addr = entry;
  assign bus.tbl_wr_ip   = ip;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cmd_wr) begin
          if (bus.reg_wdata[1:0] == 2'b01)      state_nxt = WR_WAIT;
          else if (bus.reg_wdata[1:0] == 2'b10) state_nxt = RD_WAIT;
        end
      end
      WR_WAIT, RD_WAIT: if (finish || expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy           = 1'b0;
    bus.tbl_wr_req = 1'b0;
    bus.tbl_rd_req = 1'b0;
    unique case (state)
      WR_WAIT: begin
        busy           = 1'b1;
        bus.tbl_wr_req = 1'b1;
      end
      RD_WAIT: begin
        busy           = 1'b1;
        bus.tbl_rd_req = 1'b1;
      end
      default: ;
    endcase
  end

  // IDLE holds the counter at zero, so every wait starts counting from 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)            cnt <= '0;
    else if (state == IDLE) cnt <= '0;
    else                    cnt <= cnt + TIMEOUT_BITS'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.reg_ack   <= 1'b0;
      bus.reg_rdata <= '0;
      ip            <= '0;
      entry         <= '0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      cmd_err       <= 1'b0;
    end else begin
      bus.reg_ack   <= bus.reg_req;
      bus.reg_rdata <= '0;
      if (rd_acc) begin
        unique case (addr)
          A_IP:     bus.reg_rdata <= ip;
          A_ENTRY:  bus.reg_rdata <= 32'(entry);
          A_CMD:    bus.reg_rdata <= '0;
          A_STATUS: bus.reg_rdata <= 32'({cmd_err, timeout, done, busy});
          default:  bus.reg_rdata <= '0;
        endcase
      end

      // Status read clears sticky bits, but a coincident set event wins.
      done    <= (done & ~sts_clr) | finish;
      timeout <= (timeout & ~sts_clr) | expire;
      cmd_err <= (cmd_err & ~sts_clr) | err_set;

      if (state == RD_WAIT && bus.tbl_rd_ack)      ip <= bus.tbl_rd_ip;
      else if (wr_acc && addr == A_IP && !busy)    ip <= bus.reg_wdata;

      if (wr_acc && addr == A_ENTRY && !busy) entry <= bus.reg_wdata[LUT_DEPTH_BITS-1:0];
    end
  end
endmodule

// File: tb/tb_dest_ip_filter_reg_ctrl.sv
// Randomised, self-checking bench for dest_ip_filter_reg_ctrl against a
// transaction-level model of the register file and table handshake.
module tb_dest_ip_filter_reg_ctrl;
  localparam int unsigned TB_BITS   = 4;
  localparam int unsigned REQ_LIMIT = (1 << TB_BITS) - 1;  // most cycles a req may stay up

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  dest_ip_filter_reg_ctrl_if #(.ADDR_BITS(5)) bus();

  dest_ip_filter_reg_ctrl #(
    .LUT_DEPTH(32),
    .LUT_DEPTH_BITS(5),
    .TIMEOUT_BITS(TB_BITS)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: register contents, pending table operation and its age.
  logic [31:0] m_ip;
  logic [4:0]  m_entry;
  int          m_op;     // 0 none, 1 table write pending, 2 table read pending
  int unsigned m_age;    // cycles the pending request has already been up
  bit          m_done, m_to, m_err;
  bit          m_ack;
  logic [31:0] m_rdata;

  function automatic logic [76:0] observed();
    return {bus.reg_ack, bus.reg_rdata, bus.tbl_wr_req, bus.tbl_rd_req,
            bus.tbl_wr_addr, bus.tbl_rd_addr, bus.tbl_wr_ip};
  endfunction

  function automatic logic [76:0] predicted();
    return {m_ack, m_rdata, (m_op == 1), (m_op == 2), m_entry, m_entry, m_ip};
  endfunction

  task automatic model_reset();
    m_ip = '0; m_entry = '0; m_op = 0; m_age = 0;
    m_done = 0; m_to = 0; m_err = 0; m_ack = 0; m_rdata = '0;
  endtask

  task automatic step(input bit req, input bit rnw, input logic [1:0] addr,
                      input logic [31:0] wd, input bit wack, input bit rack,
                      input logic [31:0] rip);
    bit busy, fin, tmo, clr, wr_idle;
    logic [31:0] rd;
    @(negedge clk);
    bus.reg_req = req; bus.reg_rnw = rnw; bus.reg_addr = addr; bus.reg_wdata = wd;
    bus.tbl_wr_ack = wack; bus.tbl_rd_ack = rack; bus.tbl_rd_ip = rip;

    busy    = (m_op != 0);
    fin     = (m_op == 1 && wack) || (m_op == 2 && rack);
    tmo     = busy && !fin && (m_age + 1 == REQ_LIMIT);
    wr_idle = req && !rnw && !busy;
    rd = '0;
    if (req && rnw) begin
      case (addr)
        2'd0: rd = m_ip;
        2'd1: rd = {27'b0, m_entry};
        2'd2: rd = '0;
        default: rd = {28'b0, m_err, m_to, m_done, busy};
      endcase
    end
    clr    = req && rnw && (addr == 2'd3);
    m_err  = (m_err && !clr) || (req && !rnw && busy && addr != 2'd3) ||
             (wr_idle && addr == 2'd2 && wd[1:0] == 2'b11);
    m_done = (m_done && !clr) || fin;
    m_to   = (m_to && !clr) || tmo;
    if (m_op == 2 && rack)           m_ip = rip;
    else if (wr_idle && addr == 2'd0) m_ip = wd;
    if (wr_idle && addr == 2'd1)      m_entry = wd[4:0];
    if (busy) begin
      if (fin || tmo) m_op = 0;
      else            m_age++;
    end else if (wr_idle && addr == 2'd2 && (wd[1:0] == 2'b01 || wd[1:0] == 2'b10)) begin
      m_op  = int'(wd[1:0]);
      m_age = 0;
    end
    m_ack = req; m_rdata = rd;

    @(posedge clk);
    #1;
    bus.reg_req = 1'b0; bus.tbl_wr_ack = 1'b0; bus.tbl_rd_ack = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d, 1'b0, 1'b0, '0);
  endtask

  task automatic rd(input logic [1:0] a);
    step(1'b1, 1'b1, a, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic idle(input bit wack, input bit rack, input logic [31:0] rip);
    step(1'b0, 1'b0, 2'd0, '0, wack, rack, rip);
  endtask

  task automatic test_reset();
    bus.reg_req = 0; bus.reg_rnw = 0; bus.reg_addr = 0; bus.reg_wdata = 0;
    bus.tbl_wr_ack = 0; bus.tbl_rd_ack = 0; bus.tbl_rd_ip = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (observed() !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h want=0", observed());
    end
    @(negedge clk) resetn = 1'b1;
    rd(2'd3);
    checks++;
    if (bus.reg_ack !== 1'b1 || bus.reg_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_status ack=%b got=%h want=00000000", bus.reg_ack, bus.reg_rdata);
    end
  endtask

  task automatic test_table_write();
    wr(2'd0, 32'hC0A80001);
    wr(2'd1, 32'd5);
    wr(2'd2, 32'd1);
    checks++;
    if ({bus.tbl_wr_req, bus.tbl_rd_req, bus.tbl_wr_addr, bus.tbl_wr_ip} !== {1'b1, 1'b0, 5'd5, 32'hC0A80001}) begin
      errors++; $display("FAIL wr_req_start got=%b%b/%0d/%h want=10/5/c0a80001",
                         bus.tbl_wr_req, bus.tbl_rd_req, bus.tbl_wr_addr, bus.tbl_wr_ip);
    end
    idle(0, 0, '0);
    idle(0, 0, '0);
    checks++;
    if (observed() !== predicted() || bus.tbl_wr_req !== 1'b1) begin
      errors++; $display("FAIL wr_req_hold got=%h want=%h", observed(), predicted());
    end
    idle(1, 0, '0);
    checks++;
    if (bus.tbl_wr_req !== 1'b0) begin
      errors++; $display("FAIL wr_req_drop got=%b want=0", bus.tbl_wr_req);
    end
    rd(2'd3);
    checks++;
    if (bus.reg_rdata !== 32'h2 || bus.reg_rdata !== m_rdata) begin
      errors++; $display("FAIL wr_status got=%h want=00000002", bus.reg_rdata);
    end
    rd(2'd3);
    checks++;
    if (bus.reg_rdata !== 32'h0) begin
      errors++; $display("FAIL wr_status_clear got=%h want=00000000", bus.reg_rdata);
    end
  endtask

  task automatic test_table_read();
    wr(2'd1, 32'd7);
    wr(2'd2, 32'd2);
    checks++;
    if ({bus.tbl_rd_req, bus.tbl_wr_req, bus.tbl_rd_addr} !== {1'b1, 1'b0, 5'd7}) begin
      errors++; $display("FAIL rd_req_start got=%b%b/%0d want=10/7", bus.tbl_rd_req, bus.tbl_wr_req, bus.tbl_rd_addr);
    end
    idle(0, 0, '0);
    idle(0, 1, 32'h0A000001);
    checks++;
    if (bus.tbl_rd_req !== 1'b0) begin
      errors++; $display("FAIL rd_req_drop got=%b want=0", bus.tbl_rd_req);
    end
    rd(2'd0);
    checks++;
    if (bus.reg_rdata !== 32'h0A000001) begin
      errors++; $display("FAIL rd_ip got=%h want=0a000001", bus.reg_rdata);
    end
    rd(2'd3);
    checks++;
    if (bus.reg_rdata !== 32'h2) begin
      errors++; $display("FAIL rd_status got=%h want=00000002", bus.reg_rdata);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    wr(2'd2, 32'd1);
    while (bus.tbl_wr_req === 1'b1 && n < 40) begin
      n++;
      idle(0, 0, '0);
    end
    checks++;
    if (n != int'(REQ_LIMIT)) begin
      errors++; $display("FAIL timeout_len got=%0d want=%0d", n, REQ_LIMIT);
    end
    rd(2'd3);
    checks++;
    if (bus.reg_rdata !== 32'h4 || bus.reg_rdata !== m_rdata) begin
      errors++; $display("FAIL timeout_status got=%h want=00000004", bus.reg_rdata);
    end
    idle(1, 0, '0);
    rd(2'd3);
    checks++;
    if (bus.reg_rdata !== 32'h0 || bus.tbl_wr_req !== 1'b0) begin
      errors++; $display("FAIL late_ack got=%h/%b want=00000000/0", bus.reg_rdata, bus.tbl_wr_req);
    end
  endtask

  task automatic test_busy_collision();
    wr(2'd2, 32'd1);
    wr(2'd0, 32'hFFFFFFFF);
    wr(2'd2, 32'd2);
    checks++;
    if ({bus.tbl_wr_req, bus.tbl_rd_req, bus.tbl_wr_ip} !== {1'b1, 1'b0, 32'h0A000001}) begin
      errors++; $display("FAIL busy_ignore got=%b%b/%h want=10/0a000001", bus.tbl_wr_req, bus.tbl_rd_req, bus.tbl_wr_ip);
    end
    idle(1, 0, '0);
    rd(2'd0);
    checks++;
    if (bus.reg_rdata !== 32'h0A000001) begin
      errors++; $display("FAIL busy_ip got=%h want=0a000001", bus.reg_rdata);
    end
    rd(2'd3);
    checks++;
    if (bus.reg_rdata !== 32'hA) begin
      errors++; $display("FAIL busy_status got=%h want=0000000a", bus.reg_rdata);
    end
  endtask

  task automatic test_cmd_err();
    wr(2'd2, 32'd3);
    checks++;
    if ({bus.tbl_wr_req, bus.tbl_rd_req} !== 2'b00) begin
      errors++; $display("FAIL cmd3_req got=%b%b want=00", bus.tbl_wr_req, bus.tbl_rd_req);
    end
    rd(2'd3);
    checks++;
    if (bus.reg_rdata !== 32'h8) begin
      errors++; $display("FAIL cmd3_status got=%h want=00000008", bus.reg_rdata);
    end
    wr(2'd2, 32'd0);
    rd(2'd3);
    checks++;
    if (bus.reg_rdata !== 32'h0 || {bus.tbl_wr_req, bus.tbl_rd_req} !== 2'b00) begin
      errors++; $display("FAIL cmd0_noop got=%h/%b%b want=00000000/00", bus.reg_rdata, bus.tbl_wr_req, bus.tbl_rd_req);
    end
  endtask

  task automatic test_ack_boundary();
    wr(2'd2, 32'd1);
    idle(1, 0, '0);
    checks++;
    if (bus.tbl_wr_req !== 1'b0) begin
      errors++; $display("FAIL first_cycle_ack got=%b want=0", bus.tbl_wr_req);
    end
    rd(2'd3);
    wr(2'd2, 32'd1);
    repeat (REQ_LIMIT - 1) idle(0, 0, '0);
    checks++;
    if (bus.tbl_wr_req !== 1'b1) begin
      errors++; $display("FAIL last_cycle_hold got=%b want=1", bus.tbl_wr_req);
    end
    idle(1, 0, '0);
    rd(2'd3);
    checks++;
    if (bus.reg_rdata !== 32'h2) begin
      errors++; $display("FAIL last_cycle_ack got=%h want=00000002", bus.reg_rdata);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      bit req, rnw;
      logic [1:0] a;
      logic [31:0] d;
      req = ($urandom_range(0, 2) == 0);
      rnw = $urandom_range(0, 1) != 0;
      a   = 2'($urandom_range(0, 3));
      d   = $urandom;
      step(req, rnw, a, d, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom);
      checks++;
      if (observed() !== predicted()) begin
        errors++; $display("FAIL random_cycle%0d got=%h want=%h", i, observed(), predicted());
      end
    end
    repeat (REQ_LIMIT + 1) idle(0, 0, '0);
    rd(2'd3);
  endtask

  task automatic test_async_reset();
    wr(2'd1, 32'd9);
    wr(2'd0, 32'h12345678);
    wr(2'd2, 32'd2);
    checks++;
    if (bus.tbl_rd_req !== 1'b1) begin
      errors++; $display("FAIL arst_pre got=%b want=1", bus.tbl_rd_req);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (observed() !== '0) begin
      errors++; $display("FAIL arst_immediate got=%h want=0", observed());
    end
    model_reset();
    @(negedge clk) resetn = 1'b1;
    rd(2'd0);
    checks++;
    if (bus.reg_rdata !== 32'h0) begin
      errors++; $display("FAIL arst_ip got=%h want=00000000", bus.reg_rdata);
    end
    rd(2'd1);
    checks++;
    if (bus.reg_rdata !== 32'h0) begin
      errors++; $display("FAIL arst_entry got=%h want=00000000", bus.reg_rdata);
    end
    rd(2'd3);
    checks++;
    if (bus.reg_rdata !== 32'h0 || bus.tbl_rd_req !== 1'b0) begin
      errors++; $display("FAIL arst_status got=%h/%b want=00000000/0", bus.reg_rdata, bus.tbl_rd_req);
    end
  endtask

  initial begin
    test_reset();
    test_table_write();
    test_table_read();
    test_timeout();
    test_busy_collision();
    test_cmd_err();
    test_ack_boundary();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
